// File: rtl/std_types.sv
// Shared width constants and enum types used across the request/dispatch datapath.
package std_types;

   localparam int U8  = 8;
   localparam int U16 = 16;
   localparam int U32 = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

endpackage : std_types

// File: rtl/encoder.sv
// Leading-one encoder: code = (highest set index + 1), or 0 for an all-zero input.
module encoder #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic [$clog2(DATA_WIDTH):0]   code
);

   localparam int CODE_BITS = $clog2(DATA_WIDTH) + 1;

   // Ascending scan so the last hit, i.e. the highest set bit, wins.
   always_comb begin
      code = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (in_data[i]) begin
            code = CODE_BITS'(i + 1);
         end
      end
   end

endmodule : encoder

// File: rtl/priority_drain.sv
// Accepts one request vector per handshake and emits its set bit indices one
// per output beat, highest first; the next vector may load on the final beat.
module priority_drain
   import std_types::*;
#(
   parameter  int DATA_WIDTH = U8,
   localparam int IDX_BITS   = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_BITS-1:0]   out_index,
   output logic                  out_last,
   output logic                  busy
);

   localparam int CODE_BITS = IDX_BITS + 1;

   drain_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] pending_q, pending_d;
   logic [DATA_WIDTH-1:0] clear_mask;
   logic [CODE_BITS-1:0]  enc_code;
   logic [IDX_BITS-1:0]   top_idx;
   logic                  single_bit;

   encoder #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_encoder (
      .in_data (pending_q),
      .code    (enc_code)
   );

   assign top_idx    = IDX_BITS'(enc_code - CODE_BITS'(1));
   assign single_bit = ((pending_q & (pending_q - DATA_WIDTH'(1))) == '0);
   assign clear_mask = DATA_WIDTH'(1) << top_idx;

   // Valid/ready: a transfer happens on a rising edge where both valid and
   // ready are high. in_ready in DRAIN follows out_ready combinationally so
   // the next vector can load on the edge that retires the final bit.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      out_valid = (state_q == DRAIN);
      busy      = (state_q == DRAIN);
      out_index = out_valid ? top_idx : '0;
      out_last  = out_valid && single_bit;
      in_ready  = !rst && ((state_q == IDLE) || (out_ready && out_last));

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready && (in_data != '0)) begin
               pending_d = in_data;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (!out_last) begin
                  pending_d = pending_q & ~clear_mask;
               end else begin
                  pending_d = '0;
                  state_d   = IDLE;
                  if (in_valid && in_ready && (in_data != '0)) begin
                     pending_d = in_data;
                     state_d   = DRAIN;
                  end
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

endmodule : priority_drain

// File: tb/tb_priority_drain.sv
// Directed bench for priority_drain: a queue-based model of pending indices,
// a per-cycle compare against it, and literal checks on the listed scenarios.
module tb_priority_drain;

   localparam int DW = 8;
   localparam int IW = $clog2(DW);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          busy;

   priority_drain #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   bit cmp_en = 1'b0;

   logic [IW-1:0] exp_q[$];      // indices still owed for the current vector
   int            model_log[$];  // indices the model retired
   int            dut_log[$];    // indices the DUT handed over
   int            dut_cyc[$];
   int            want_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic chk_seq(input string name);
      chk({name, "_dut_len"}, dut_log.size(), want_q.size());
      chk({name, "_model_len"}, model_log.size(), want_q.size());
      for (int i = 0; i < want_q.size(); i++) begin
         if (i < dut_log.size())   chk({name, "_dut_idx"}, dut_log[i], want_q[i]);
         if (i < model_log.size()) chk({name, "_model_idx"}, model_log[i], want_q[i]);
      end
   endtask

   // Model: a vector becomes a descending list of its set indices; one is
   // retired per accepted beat, and a new vector is taken only when the list
   // is empty or is retiring its last entry.
   function automatic bit model_in_ready();
      return !rst && ((exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
   endfunction

   always @(posedge clk) begin
      bit take;
      cycle++;
      if (rst) begin
         exp_q.delete();
      end else begin
         take = in_valid && model_in_ready();
         if (exp_q.size() != 0 && out_ready) begin
            model_log.push_back(int'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         if (take) begin
            for (int i = DW - 1; i >= 0; i--) begin
               if (in_data[i]) exp_q.push_back(IW'(i));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
         chk("busy", int'(busy), int'(exp_q.size() != 0));
         chk("out_index", int'(out_index), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
         chk("out_last", int'(out_last), int'(exp_q.size() == 1));
         chk("in_ready", int'(in_ready), int'(model_in_ready()));
      end
      if (out_valid && out_ready && !rst) begin
         dut_log.push_back(int'(out_index));
         dut_cyc.push_back(cycle);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      dut_log.delete();
      dut_cyc.delete();
      model_log.delete();
   endtask

   // Offers a vector and returns #1 after the accepting edge, or flags a timeout.
   task automatic send_vec(input logic [DW-1:0] v);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   initial begin
      // Reset
      @(negedge clk);
      chk("in_ready_in_rst", int'(in_ready), 0);
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_index", int'(out_index), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      // 1010_0110 drained under continuous out_ready
      @(posedge clk);
      #1;
      clear_logs();
      out_ready = 1'b1;
      send_vec(8'b1010_0110);
      wait_cycles(5);
      want_q = '{7, 5, 2, 1};
      chk_seq("a6");
      @(negedge clk);
      chk("a6_busy_fell", int'(busy), 0);

      // Zero vector: one handshake, no beat
      clear_logs();
      send_vec(8'h00);
      @(negedge clk);
      chk("zero_out_valid", int'(out_valid), 0);
      chk("zero_in_ready", int'(in_ready), 1);
      chk("zero_busy", int'(busy), 0);
      wait_cycles(2);
      chk("zero_no_beats", dut_log.size(), 0);

      // Stall on 8'h81
      clear_logs();
      out_ready = 1'b0;
      send_vec(8'h81);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_index", int'(out_index), 7);
         chk("stall_in_ready", int'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_cycles(3);
      want_q = '{7, 0};
      chk_seq("stall");

      // Back-to-back 8'h03 then 8'h80 with in_valid held
      clear_logs();
      send_vec(8'h03);
      send_vec(8'h80);
      wait_cycles(3);
      want_q = '{1, 0, 7};
      chk_seq("b2b");
      if (dut_cyc.size() == 3) chk("b2b_no_gap", dut_cyc[2] - dut_cyc[0], 2);
      else chk("b2b_cyc_count", dut_cyc.size(), 3);

      // Reset in the middle of draining 8'hFF
      clear_logs();
      send_vec(8'hFF);
      wait_cycles(2);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_in_ready_rel", int'(in_ready), 1);
      wait_cycles(4);
      want_q = '{7, 6};
      chk_seq("mid_rst");

      // Single bit 8'h01: beat one cycle after accept
      clear_logs();
      send_vec(8'h01);
      @(negedge clk);
      chk("single_valid", int'(out_valid), 1);
      chk("single_index", int'(out_index), 0);
      chk("single_last", int'(out_last), 1);
      wait_cycles(2);
      want_q = '{0};
      chk_seq("single");

      // Mixed pattern with out_ready toggling
      clear_logs();
      send_vec(8'h5A);
      for (int i = 0; i < 12; i++) begin
         out_ready = i[0];
         wait_cycles(1);
      end
      out_ready = 1'b1;
      wait_cycles(3);
      want_q = '{6, 4, 3, 1};
      chk_seq("toggle");

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_priority_drain

// File: doc/priority_drain.md
# priority_drain

Sequential consumer of the leading-one `encoder`. It accepts one request bit-vector per valid/ready handshake and holds it in a pending register. It then emits the set bit indices one per accepted output beat, highest index first, clearing each bit as it is emitted. It sits directly downstream of request collection and feeds grant or dispatch logic that needs serialized indices rather than a one-hot or multi-hot vector.

## Interface
- `DATA_WIDTH`, default 8: request vector width; must be ≥ 2.
- `IDX_BITS`, localparam, `$clog2(DATA_WIDTH)`: width of an emitted index.
- `clk` input, 1: sole clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: `in_data` is offered.
- `in_ready` output, 1: block accepts `in_data` this cycle.
- `in_data` input, `DATA_WIDTH`: request vector; bit i set means request i is pending.
- `out_valid` output, 1: `out_index` is valid.
- `out_ready` input, 1: downstream consumes `out_index` this cycle.
- `out_index` output, `IDX_BITS`: highest pending request index.
- `out_last` output, 1: `out_index` is the final pending bit of the current vector.
- `busy` output, 1: a vector is being drained (state DRAIN).

## Operation
- State: `pending[DATA_WIDTH-1:0]` and a 2-state FSM, IDLE / DRAIN.
- An `encoder` instance is driven by `pending`. It returns code c = (highest set index + 1), or 0 if `pending` is 0.
- `out_index` = c − 1, truncated to `IDX_BITS`. Forced to 0 whenever `out_valid` = 0.
- `out_last` = `out_valid` && ((`pending` & (`pending` − 1)) == 0).
- IDLE:
  - `in_ready` = 1 and `out_valid` = 0.
  - On accept with `in_data` ≠ 0: `pending` ← `in_data`; go to DRAIN.
  - On accept with `in_data` = 0: the vector is consumed and dropped. No output beat, stay IDLE.
- DRAIN:
  - `out_valid` = 1.
  - On `out_ready` with `out_last` = 0: clear bit `out_index` in `pending`; stay DRAIN.
  - On `out_ready` with `out_last` = 1: `pending` is cleared.
- Turnaround in DRAIN:
  - `in_ready` = `out_ready` && `out_last`; this is a combinational path, and is intentional.
  - If `in_valid` is also high, the new vector is loaded in the same edge that clears the final bit.
  - The next state is DRAIN if the new vector ≠ 0, otherwise IDLE.
  - With `in_valid` low, the next state is IDLE.
- `in_data` bits not in `pending` are never merged: one vector is drained to completion before the next is taken.
- `out_index` and `out_last` are stable while `out_valid` && !`out_ready`, because `pending` changes only on a handshake.

## Timing
- Reset, `rst` high at an edge:
  - `pending` ← 0 and state ← IDLE.
  - Outputs after that edge: `out_valid` = 0, `out_index` = 0, `out_last` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-drain: the remaining pending bits are discarded. No further beats are emitted for that vector.
- Latency: a vector accepted at edge N gives `out_valid` = 1 in the cycle after edge N.
- Throughput: a vector with k set bits occupies exactly k output beats under continuous `out_ready`. Back-to-back vectors have zero bubble cycles.
- A zero vector costs one input handshake and no output cycle.
- With `out_ready` held low, the block stalls indefinitely with outputs frozen and `in_ready` = 0.

## Structure
- The FSM state enum type (IDLE, DRAIN) belongs in the shared `std_types` package, alongside existing width constants such as `U8`.
- One sub-module: the existing `encoder`, instantiated with `DATA_WIDTH`. Its output width is `$clog2(DATA_WIDTH)+1`, and the block reduces that to `IDX_BITS` after subtracting 1.
- All other logic (pending register, bit clear via a decoded one-hot mask, FSM, handshakes) is local.

## Test plan
- Reset, then `in_data` = 8'b1010_0110 with `out_ready` held 1: four beats, `out_index` = 7, 5, 2, 1; `out_last` = 1 only on index 1; `busy` falls after the fourth beat.
- `in_data` = 8'h00 accepted: no `out_valid` pulse, `in_ready` stays 1, state stays IDLE.
- Stall: `in_data` = 8'h81 with `out_ready` low for 5 cycles:
  - `out_index` = 7 is held and `in_ready` = 0 throughout.
  - Then `out_ready` = 1 gives beats 7 and 0.
- Back-to-back: 8'h03 then 8'h80, with `in_valid` held: the beat sequence is 1, 0, 7 with no gap; the second vector is accepted on the `out_last` beat of the first.
- Mid-drain reset: 8'hFF, two beats (7, 6), then `rst` for 1 cycle: `out_valid` = 0 next cycle, `in_ready` = 1 after release, no indices 5..0 emitted.
- Single bit 8'h01: one beat with `out_index` = 0 and `out_last` = 1, latency exactly 1 cycle from accept.
